axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Shares the single AXI read port (AR and R channels) of the NPC memory interface between two read requesters: m0 (IFU instruction fetch) and m1 (LSU load). It sits between the two requesters and the read side of the AXI master/slave link, grants one requester at a time, and routes the R response back to the granted requester. It allows one outstanding read in total and supports no bursts.

## Interface
- DWIDTH, 32, data width of RDATA
- AWIDTH, 64, address width of ARADDR
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- m0_arvalid  in  1  IFU read-address valid
- m0_arready  out  1  IFU read-address ready
- m0_araddr  in  AWIDTH  IFU read address
- m0_rvalid  out  1  IFU read-data valid
- m0_rready  in  1  IFU read-data ready
- m0_rdata  out  DWIDTH  IFU read data
- m0_rresp  out  2  IFU read response
- m1_arvalid, m1_arready, m1_araddr, m1_rvalid, m1_rready, m1_rdata, m1_rresp: LSU, same directions and widths as m0_*
- s_arvalid  out  1  downstream read-address valid
- s_arready  in  1  downstream read-address ready
- s_araddr  out  AWIDTH  downstream read address
- s_rvalid  in  1  downstream read-data valid
- s_rready  out  1  downstream read-data ready
- s_rdata  in  DWIDTH  downstream read data
- s_rresp  in  2  downstream read response

## Operation
- The FSM has three states: IDLE, ADDR and DATA. A 1-bit register `gnt` holds the granted requester, and a 1-bit register `last` holds the last grant.
- IDLE
  - If any mx_arvalid is high, latch `gnt` from the picker and go to ADDR.
  - Otherwise stay in IDLE.
- ADDR
  - s_arvalid = m[gnt]_arvalid, s_araddr = m[gnt]_araddr, m[gnt]_arready = s_arready.
  - When s_arvalid && s_arready, go to DATA.
- DATA
  - m[gnt]_rvalid = s_rvalid, m[gnt]_rdata = s_rdata, m[gnt]_rresp = s_rresp, s_rready = m[gnt]_rready.
  - When s_rvalid && s_rready, update `last` to `gnt` and go to IDLE.
- All routing is combinational from the state and `gnt`; no data is buffered.
- A non-granted requester sees arready=0, rvalid=0, rdata=0 and rresp=0.
- In IDLE all s_* outputs and all m*_ outputs are 0.
- The grant is fixed from IDLE exit until the R handshake. A higher-priority arrival during ADDR or DATA waits.
- If the granted requester drops arvalid in ADDR (an AXI violation), the FSM stays in ADDR and s_arvalid follows it low. No grant change occurs.
- RRESP is passed through unmodified, with no error handling.

## Timing
- Reset: state=IDLE, gnt=0, last=1. Every output is 0 in the cycle after ARESET is sampled high.
- ARESET asserted mid-transaction abandons it. The downstream side shares ARESET.
- Request latency:
  - m_arvalid sampled high in IDLE in cycle N gives s_arvalid=1 in cycle N+1.
  - The AR handshake can complete in N+1 at the earliest.
- R latency: zero cycles added. rvalid and rready pass through in the same cycle.
- Turnaround: after the R handshake in cycle M, the FSM is in IDLE in M+1. The next grant decision happens in M+1 and the next s_arvalid in M+2.
- Minimum read is 3 cycles, with a 1-cycle idle bubble between back-to-back reads.
- Requesters must hold arvalid and araddr stable until arready (AXI rule). The arbiter relies on this.

## Configuration
- Macro: `AXI_RD_ARB_RR_EN`.
- Defined: round-robin on a tie.
  - If both requesters request in IDLE, grant the one that is not `last`.
  - With the reset value last=1, m0 wins the first tie.
- Undefined: fixed priority. m1 (LSU) always wins a tie, and `last` is unused (it may be optimized away).
- A single requester is granted immediately in either mode.

## Structure
- Shared package `axi_pkg` holds:
  - state localparams IDLE=2'b00, ADDR=2'b01, DATA=2'b10;
  - RRESP codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- Sub-module `axi_arb_pick` is combinational. It takes req[1:0] and last, and outputs gnt_idx. It contains the `AXI_RD_ARB_RR_EN` selection.
- Top-level: FSM, gnt/last registers, channel muxes.

## Test plan
- Single m0 read: m0_araddr=0x8000_0000 in IDLE; slave arready at once, rvalid 2 cycles later with rdata=0x0000_0413.
  - s_arvalid rises the next cycle.
  - m0 receives rdata=0x0000_0413 with rresp=OKAY.
  - m1_rvalid stays 0 throughout.
- Simultaneous requests, m0=0x8000_0004 and m1=0x8000_1000:
  - Fixed priority: m1 is granted first, then m0.
  - With `AXI_RD_ARB_RR_EN`: m0 first, then m1, then alternation over 4 more tie rounds.
- Backpressure:
  - s_arready is held low for 5 cycles: s_araddr stays stable, m_arready stays 0, and the state stays ADDR.
  - m_rready is held low for 3 cycles while s_rvalid=1: s_rready=0 and the FSM stays in DATA.
- Late arrival: m1 asserts arvalid while an m0 read is in DATA. m1 is not granted until the cycle after the m0 R handshake, and s_arvalid for m1 appears 2 cycles after that handshake.
- Error passthrough: slave returns rresp=SLVERR and rdata=0xDEAD_BEEF to m1. m1 sees both values exactly, and the FSM returns to IDLE.
- Reset mid-DATA: ARESET is pulsed for 1 cycle. The next cycle has state IDLE and all outputs 0, and a fresh m0 read then completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared constants for the NPC read-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ADDR, DATA)
//   OKAY/EXOKAY/SLVERR/DECERR : AXI RRESP codes
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } arb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI read-only link (AR + R channels, no bursts).
//   arvalid/arready/araddr : read address channel
//   rvalid/rready/rdata/rresp : read data channel
//   mst : address issuer / data consumer side
//   slv : address acceptor / data producer side
interface axi_rd_arbiter_if #(
    parameter int AWIDTH = 64,
    parameter int DWIDTH = 32
);
    logic              arvalid;
    logic              arready;
    logic [AWIDTH-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DWIDTH-1:0] rdata;
    logic [1:0]        rresp;

    modport mst (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slv (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_arb_pick.sv
// axi_arb_pick: combinational tie-breaker for the two read requesters.
//   req[1:0] : in  arvalid of m1 (bit 1) and m0 (bit 0)
//   last     : in  requester granted by the previous completed read
//   gnt_idx  : out requester to grant (meaningful only when req != 0)
// AXI_RD_ARB_RR_EN defined   : a tie goes to the requester that is not last.
// AXI_RD_ARB_RR_EN undefined : a tie always goes to m1 (LSU); last ignored.
module axi_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx
);
`ifdef AXI_RD_ARB_RR_EN
    assign gnt_idx = (req == 2'b11) ? ~last : req[1];
`else
    // With m1 fixed as winner, only req[1] matters.
    logic unused_ok;
    assign unused_ok = &{1'b0, last, req[0]};
    assign gnt_idx   = req[1];
`endif
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read port between IFU (m0) and LSU (m1).
// One outstanding read in total; the grant is held from IDLE exit until
// the R handshake, and all routing is combinational (no buffering).
//   ACLK, ARESET : clock, synchronous active-high reset
//   m0, m1       : requester links (slv modport)
//   s            : downstream link (mst modport)
// Tie-break mode selected by AXI_RD_ARB_RR_EN (see axi_arb_pick).
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 64
) (
    input  logic          ACLK,
    input  logic          ARESET,
    axi_rd_arbiter_if.slv m0,
    axi_rd_arbiter_if.slv m1,
    axi_rd_arbiter_if.mst s
);
    arb_state_e        state, state_nxt;
    logic              gnt, gnt_nxt;
    logic              last, last_nxt;
    logic              pick;
    logic              in_addr, in_data;
    logic              sel_arvalid, sel_rready;
    logic [AWIDTH-1:0] sel_araddr;
    logic [DWIDTH-1:0] rdata_g;
    logic [1:0]        rresp_g;

    axi_arb_pick u_pick (
        .req     ({m1.arvalid, m0.arvalid}),
        .last    (last),
        .gnt_idx (pick)
    );

    assign sel_arvalid = gnt ? m1.arvalid : m0.arvalid;
    assign sel_araddr  = gnt ? m1.araddr  : m0.araddr;
    assign sel_rready  = gnt ? m1.rready  : m0.rready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        case (state)
            IDLE: if (m0.arvalid || m1.arvalid) begin
                gnt_nxt   = pick;
                state_nxt = ADDR;
            end
            // A granted requester dropping arvalid here just stalls in ADDR.
            ADDR: if (sel_arvalid && s.arready) state_nxt = DATA;
            DATA: if (s.rvalid && sel_rready) begin
                last_nxt  = gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    // Everything gated by state so IDLE drives all-zero on both sides.
    assign s.arvalid  = in_addr & sel_arvalid;
    assign s.araddr   = in_addr ? sel_araddr : '0;
    assign s.rready   = in_data & sel_rready;

    assign m0.arready = in_addr & ~gnt & s.arready;
    assign m1.arready = in_addr &  gnt & s.arready;

    assign rdata_g    = in_data ? s.rdata : '0;
    assign rresp_g    = in_data ? s.rresp : 2'b00;

    assign m0.rvalid  = in_data & ~gnt & s.rvalid;
    assign m0.rdata   = gnt ? '0 : rdata_g;
    assign m0.rresp   = gnt ? 2'b00 : rresp_g;

    assign m1.rvalid  = in_data & gnt & s.rvalid;
    assign m1.rdata   = gnt ? rdata_g : '0;
    assign m1.rresp   = gnt ? rresp_g : 2'b00;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter.
// Expected reads are queued in grant order as stimulus is driven and
// compared when a requester completes an R handshake. Tie ordering follows
// AXI_RD_ARB_RR_EN.
module tb_axi_rd_arbiter;
    import axi_pkg::*;

    localparam int AW = 64;
    localparam int DW = 32;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axi_rd_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m0_if ();
    axi_rd_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m1_if ();
    axi_rd_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) s_if ();

    axi_rd_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if)
    );

    // requester-side arrays, index = requester id
    logic          m_arvalid [2];
    logic [AW-1:0] m_araddr  [2];
    logic          m_rready  [2];
    logic          m_arready [2];
    logic          m_rvalid  [2];
    logic [DW-1:0] m_rdata   [2];
    logic [1:0]    m_rresp   [2];

    assign m0_if.arvalid = m_arvalid[0];
    assign m0_if.araddr  = m_araddr[0];
    assign m0_if.rready  = m_rready[0];
    assign m1_if.arvalid = m_arvalid[1];
    assign m1_if.araddr  = m_araddr[1];
    assign m1_if.rready  = m_rready[1];
    assign m_arready[0]  = m0_if.arready;
    assign m_rvalid[0]   = m0_if.rvalid;
    assign m_rdata[0]    = m0_if.rdata;
    assign m_rresp[0]    = m0_if.rresp;
    assign m_arready[1]  = m1_if.arready;
    assign m_rvalid[1]   = m1_if.rvalid;
    assign m_rdata[1]    = m1_if.rdata;
    assign m_rresp[1]    = m1_if.rresp;

    // downstream slave model outputs
    logic          sl_arready;
    logic          sl_rvalid;
    logic [DW-1:0] sl_rdata;
    logic [1:0]    sl_rresp;
    assign s_if.arready = sl_arready;
    assign s_if.rvalid  = sl_rvalid;
    assign s_if.rdata   = sl_rdata;
    assign s_if.rresp   = sl_rresp;

    logic [1:0] st;
    assign st = dut.state;

    // knobs
    int            ar_stall = 0;
    int            r_lat    = 2;
    logic          force_en = 1'b0;
    logic [DW-1:0] force_data = '0;
    logic [1:0]    sl_resp  = OKAY;
    int            rr_stall [2] = '{0, 0};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0413;
        return a[31:0] ^ 32'hA5A5_0F0F;
    endfunction

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;
    exp_t sb[$];
    logic tb_last = 1'b1;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int   rise_cyc [2] = '{0, 0};
    int   rhs_cyc  [2] = '{0, 0};
    int   n_arstall = 0;
    int   n_rstall  = 0;

    // ---------------- slave model ----------------
    initial begin
        int            phase;
        int            cnt;
        int            stall_left;
        logic          rst_s, ar_hs, r_hs, arv;
        logic [AW-1:0] addr_s, cur_addr;
        phase = 0; cnt = 0; stall_left = 0; cur_addr = '0;
        sl_arready = 1'b0; sl_rvalid = 1'b0; sl_rdata = '0; sl_rresp = 2'b00;
        forever begin
            @(negedge ACLK);
            rst_s  = ARESET;
            ar_hs  = s_if.arvalid && s_if.arready;
            r_hs   = s_if.rvalid && s_if.rready;
            arv    = s_if.arvalid;
            addr_s = s_if.araddr;
            @(posedge ACLK); #1;
            if (rst_s) begin
                phase = 0; sl_arready = 1'b0; sl_rvalid = 1'b0;
                sl_rdata = '0; sl_rresp = 2'b00; stall_left = ar_stall;
            end else begin
                case (phase)
                    0: if (ar_hs) begin
                        sl_arready = 1'b0;
                        cur_addr   = addr_s;
                        if (r_lat <= 1) begin
                            sl_rvalid = 1'b1;
                            sl_rdata  = force_en ? force_data : mem_data(cur_addr);
                            sl_rresp  = sl_resp;
                            phase     = 2;
                        end else begin
                            cnt   = r_lat - 1;
                            phase = 1;
                        end
                    end else begin
                        if (!arv) stall_left = ar_stall;
                        else if (stall_left > 0) stall_left--;
                        sl_arready = (stall_left == 0);
                    end
                    1: if (cnt <= 1) begin
                        sl_rvalid = 1'b1;
                        sl_rdata  = force_en ? force_data : mem_data(cur_addr);
                        sl_rresp  = sl_resp;
                        phase     = 2;
                    end else cnt--;
                    default: if (r_hs) begin
                        sl_rvalid  = 1'b0; sl_rdata = '0; sl_rresp = 2'b00;
                        phase      = 0;
                        stall_left = ar_stall;
                        sl_arready = (ar_stall == 0);
                    end
                endcase
            end
        end
    end

    // ---------------- requester driver ----------------
    initial begin
        logic arhs [2];
        logic rv   [2];
        for (int k = 0; k < 2; k++) begin
            m_arvalid[k] = 1'b0; m_araddr[k] = '0; m_rready[k] = 1'b1;
        end
        forever begin
            @(negedge ACLK);
            for (int k = 0; k < 2; k++) begin
                arhs[k] = m_arvalid[k] && m_arready[k];
                rv[k]   = m_rvalid[k];
            end
            @(posedge ACLK); #1;
            for (int k = 0; k < 2; k++) begin
                if (arhs[k]) m_arvalid[k] = 1'b0;
                if (rv[k] && rr_stall[k] > 0) rr_stall[k]--;
                m_rready[k] = (rr_stall[k] == 0);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev_sarv;
        prev_sarv = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (s_if.arvalid && !prev_sarv && sb.size() > 0) rise_cyc[sb[0].id] = cyc;
                if (s_if.arvalid && sb.size() == 0) chk("ar_unexpected", 1, 0);
                if (s_if.arvalid && s_if.arready && sb.size() > 0) begin
                    chk("ar_addr", s_if.araddr, sb[0].addr);
                    chk("ar_rdy_gnt", m_arready[sb[0].id], 1);
                    chk("ar_rdy_other", m_arready[1 - sb[0].id], 0);
                end
                if (s_if.arvalid && !s_if.arready && sb.size() > 0) begin
                    n_arstall++;
                    chk("stall_addr", s_if.araddr, sb[0].addr);
                    chk("stall_arrdy", m_arready[0] | m_arready[1], 0);
                    chk("stall_state", st, ADDR);
                end
                for (int k = 0; k < 2; k++) begin
                    if (m_rvalid[k]) begin
                        if (sb.size() == 0) chk("rv_unexpected", 1, 0);
                        else begin
                            chk("rv_route", k, sb[0].id);
                            if (m_rready[k]) begin
                                chk("rdata", m_rdata[k], sb[0].data);
                                chk("rresp", m_rresp[k], sb[0].resp);
                                rhs_cyc[k] = cyc;
                                void'(sb.pop_front());
                            end else begin
                                n_rstall++;
                                chk("rstall_srdy", s_if.rready, 0);
                                chk("rstall_state", st, DATA);
                            end
                        end
                    end
                end
            end
            prev_sarv = s_if.arvalid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic push_exp(input int k, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [1:0] r);
        exp_t e;
        e.id = k; e.addr = a; e.data = d; e.resp = r;
        sb.push_back(e);
        tb_last = k[0];
    endtask

    task automatic issue(input int k, input logic [AW-1:0] a);
        m_arvalid[k] = 1'b1;
        m_araddr[k]  = a;
    endtask

    task automatic wait_done(input int budget);
        int  n;
        logic done;
        n = 0; done = 1'b0;
        while (!done && n < budget) begin
            @(negedge ACLK);
            n++;
            done = (sb.size() == 0) && (st == IDLE) && !m_arvalid[0] && !m_arvalid[1];
        end
        if (!done) chk("timeout_done", 0, 1);
        tick(1);
    endtask

    task automatic wait_arhs(input int k, input int budget);
        int  n;
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge ACLK);
            n++;
            seen = m_arvalid[k] && m_arready[k];
        end
        if (!seen) chk("timeout_arhs", 0, 1);
        tick(1);
    endtask

    function automatic logic outs_any();
        return |{s_if.arvalid, s_if.araddr, s_if.rready,
                 m0_if.arready, m0_if.rvalid, m0_if.rdata, m0_if.rresp,
                 m1_if.arready, m1_if.rvalid, m1_if.rdata, m1_if.rresp};
    endfunction

    initial begin
        int            n0;
        int            first;
        logic [AW-1:0] a0, a1;

        // reset state
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_state", st, IDLE);
        chk("rst_outs", outs_any(), 0);
        chk("rst_gnt", dut.gnt, 0);
        chk("rst_last", dut.last, 1);
        tick(1);
        ARESET = 1'b0;
        tick(2);

        // single m0 read, rvalid 2 cycles after AR handshake
        r_lat = 2;
        n0 = cyc;
        push_exp(0, 64'h8000_0000, 32'h0000_0413, OKAY);
        issue(0, 64'h8000_0000);
        wait_done(50);
        chk("m0_ar_lat", rise_cyc[0] - n0, 1);
        chk("m0_r_lat", rhs_cyc[0] - n0, 3);

        // minimum-length read on m1
        r_lat = 1;
        n0 = cyc;
        push_exp(1, 64'h8000_2000, mem_data(64'h8000_2000), OKAY);
        issue(1, 64'h8000_2000);
        wait_done(50);
        chk("min_read_len", rhs_cyc[1] - n0, 2);

        // tie rounds
        r_lat = 2;
        for (int r = 0; r < 5; r++) begin
            a0 = 64'h8000_0004 + 64'(r * 8);
            a1 = 64'h8000_1000 + 64'(r * 8);
`ifdef AXI_RD_ARB_RR_EN
            first = tb_last ? 0 : 1;
`else
            first = 1;
`endif
            if (first == 0) begin
                push_exp(0, a0, mem_data(a0), OKAY);
                push_exp(1, a1, mem_data(a1), OKAY);
            end else begin
                push_exp(1, a1, mem_data(a1), OKAY);
                push_exp(0, a0, mem_data(a0), OKAY);
            end
            issue(0, a0);
            issue(1, a1);
            wait_done(80);
            chk("tie_gap", rise_cyc[1 - first] - rhs_cyc[first], 2);
        end

        // backpressure on AR and R
        ar_stall = 5;
        rr_stall[0] = 3;
        n_arstall = 0;
        n_rstall  = 0;
        push_exp(0, 64'h8000_0100, mem_data(64'h8000_0100), OKAY);
        issue(0, 64'h8000_0100);
        wait_done(80);
        chk("ar_stall_cycles", n_arstall, 5);
        chk("r_stall_cycles", n_rstall, 3);
        ar_stall = 0;

        // late arrival of m1 while m0 is in DATA
        r_lat = 3;
        push_exp(0, 64'h8000_0200, mem_data(64'h8000_0200), OKAY);
        issue(0, 64'h8000_0200);
        wait_arhs(0, 30);
        chk("late_in_data", st, DATA);
        push_exp(1, 64'h8000_1100, mem_data(64'h8000_1100), OKAY);
        issue(1, 64'h8000_1100);
        wait_done(80);
        chk("late_gap", rise_cyc[1] - rhs_cyc[0], 2);

        // error response passthrough to m1
        r_lat = 2;
        sl_resp = SLVERR;
        force_en = 1'b1;
        force_data = 32'hDEAD_BEEF;
        push_exp(1, 64'h8000_3000, 32'hDEAD_BEEF, SLVERR);
        issue(1, 64'h8000_3000);
        wait_done(50);
        chk("err_idle", st, IDLE);
        sl_resp = OKAY;
        force_en = 1'b0;

        // reset pulse while in DATA
        r_lat = 5;
        push_exp(0, 64'h8000_0300, mem_data(64'h8000_0300), OKAY);
        issue(0, 64'h8000_0300);
        wait_arhs(0, 30);
        chk("rst_mid_in_data", st, DATA);
        ARESET = 1'b1;
        sb.delete();
        tb_last = 1'b1;
        tick(1);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_mid_state", st, IDLE);
        chk("rst_mid_outs", outs_any(), 0);
        tick(1);
        r_lat = 2;
        n0 = cyc;
        push_exp(0, 64'h8000_0000, 32'h0000_0413, OKAY);
        issue(0, 64'h8000_0000);
        wait_done(50);
        chk("post_rst_lat", rhs_cyc[0] - n0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
